// File: rtl/uart_bus_pkg.sv
// Shared types for the UART host-side bus master: FSM state encoding and
// read_write_o polarity constants.
package uart_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRecover
  } bus_fsm_e;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable
// reset value and synchronous active-low reset.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_bus_master.sv
// Host-side bus master sequencing SETUP/STROBE/RECOVER cycles on the UART
// register port. Define UART_BUS_MASTER_AUTO_IRQ_EN to enable auto IRQ-ID fetch.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter logic [2:0]  IRQ_ID_ADDR = 3'd0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_address_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       chip_sel_n_o,
  output logic [2:0] address_o,
  output logic       read_write_o,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  input  logic [7:0] data_i,
  input  logic       ireq_n_i,
  output logic       irq_o,
  output logic       irq_id_valid_o,
  output logic [2:0] irq_id_o
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

  bus_fsm_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cs_n_q, cs_n_d;
  logic [2:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            oe_q, oe_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ready_q, ready_d;

  logic ireq_n_sync;
  logic strobe_done;
  logic fetch_go;
  logic is_fetch;
  logic hold_off;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_irq_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (ireq_n_i),
    .q_o    (ireq_n_sync)
  );

  assign irq_o       = ~ireq_n_sync;
  assign strobe_done = (state_q == StStrobe) && (cnt_q == '0);

`ifdef UART_BUS_MASTER_AUTO_IRQ_EN
  logic       arm_q, arm_d;
  logic       fetch_q, fetch_d;
  logic       irq_prev_q;
  logic       id_valid_q, id_valid_d;
  logic [2:0] id_q, id_d;
  logic       irq_rise;

  assign irq_rise = irq_o & ~irq_prev_q;
  assign fetch_go = (state_q == StIdle) && arm_q;
  assign is_fetch = fetch_q;

  always_comb begin
    arm_d      = fetch_go ? irq_rise : (arm_q | irq_rise);
    fetch_d    = (state_q == StIdle) ? fetch_go : fetch_q;
    id_valid_d = strobe_done && fetch_q;
    id_d       = id_valid_d ? data_i[2:0] : id_q;
    hold_off   = arm_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      arm_q      <= 1'b0;
      fetch_q    <= 1'b0;
      irq_prev_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_q       <= '0;
    end else begin
      arm_q      <= arm_d;
      fetch_q    <= fetch_d;
      irq_prev_q <= irq_o;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
    end
  end

  assign irq_id_valid_o = id_valid_q;
  assign irq_id_o       = id_q;
`else
  assign fetch_go       = 1'b0;
  assign is_fetch       = 1'b0;
  assign hold_off       = 1'b0;
  assign irq_id_valid_o = 1'b0;
  assign irq_id_o       = 3'd0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_go) begin
          addr_d  = IRQ_ID_ADDR;
          rw_d    = READ;
          oe_d    = 1'b0;
          state_d = StSetup;
        end else if (req_valid_i && ready_q) begin
          addr_d  = req_address_i;
          rw_d    = req_write_i ? WRITE : READ;
          wdata_d = req_wdata_i;
          oe_d    = req_write_i;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cs_n_d  = 1'b0;
        cnt_d   = HoldLoad;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (strobe_done) begin
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          rw_d    = READ;
          cnt_d   = GapLoad;
          state_d = StRecover;
          // Internal ID fetches complete silently on the host response port.
          if (!is_fetch) begin
            rsp_valid_d = 1'b1;
            rdata_d     = (rw_q == READ) ? data_i : 8'h00;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase

    ready_d = (state_d == StIdle) && !hold_off;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      addr_q      <= '0;
      rw_q        <= READ;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign chip_sel_n_o = cs_n_q;
  assign address_o    = addr_q;
  assign read_write_o = rw_q;
  assign data_o       = wdata_q;
  assign data_oe_o    = oe_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: random host traffic against a simple
// register-file UART model, plus directed timing, reset and interrupt cases.
module tb_uart_bus_master;

  localparam int unsigned H = 2;
  localparam int unsigned G = 1;

  logic       clk_i;
  logic       rst_n;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_write_i;
  logic [2:0] req_address_i;
  logic [7:0] req_wdata_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       chip_sel_n_o;
  logic [2:0] address_o;
  logic       read_write_o;
  logic [7:0] data_o;
  logic       data_oe_o;
  logic [7:0] data_i;
  logic       ireq_n_i;
  logic       irq_o;
  logic       irq_id_valid_o;
  logic [2:0] irq_id_o;

  uart_bus_master dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_address_i (req_address_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .chip_sel_n_o  (chip_sel_n_o),
    .address_o     (address_o),
    .read_write_o  (read_write_o),
    .data_o        (data_o),
    .data_oe_o     (data_oe_o),
    .data_i        (data_i),
    .ireq_n_i      (ireq_n_i),
    .irq_o         (irq_o),
    .irq_id_valid_o(irq_id_valid_o),
    .irq_id_o      (irq_id_o)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned id_cyc = 0;
  int unsigned rsp_cyc = 0;
  bit proto_en = 0;

  logic [7:0] uart_mem [8];
  logic [7:0] ref_mem [8];
  logic [7:0] exp_q [$];
  logic [2:0] id_q [$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // UART register-file model: writes land while strobed, reads are combinational.
  always @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) uart_mem[i] <= 8'h00;
    end else if (!chip_sel_n_o && data_oe_o && !read_write_o) begin
      uart_mem[address_o] <= data_o;
    end
  end
  assign data_i = uart_mem[address_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Response and IRQ-ID monitor
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rsp_valid_o === 1'b1) begin
        rsp_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else check("rsp_rdata", rsp_rdata_o, exp_q.pop_front());
      end
      if (irq_id_valid_o === 1'b1) begin
        id_cyc = cyc;
        if (id_q.size() == 0) check("unexpected_irq_id", 1, 0);
        else check("irq_id", irq_id_o, id_q.pop_front());
      end
    end
  end

  // Bus protocol monitor: strobe width, recovery gap, drive direction
  initial begin
    int  low_run;
    int  high_run;
    bit  seen;
    logic prev_cs;
    low_run = 0; high_run = 0; seen = 0; prev_cs = 1'b1;
    forever begin
      @(negedge clk_i);
      if (!proto_en) begin
        low_run = 0; high_run = 0; seen = 0; prev_cs = 1'b1;
      end else if (chip_sel_n_o == 1'b0) begin
        if (prev_cs && seen) check("cs_gap_ge_g_plus_1", (high_run >= G + 1), 1);
        check("oe_matches_write", data_oe_o, !read_write_o);
        low_run++;
        high_run = 0;
        prev_cs = 1'b0;
      end else begin
        if (!prev_cs) begin
          check("cs_low_width", low_run, H);
          seen = 1;
        end
        low_run = 0;
        high_run++;
        prev_cs = 1'b1;
      end
    end
  end

  // Entered and left on a negedge; leaves req_valid_i high.
  task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input bit expect_rsp);
    int n;
    n = 0;
    req_write_i   = w;
    req_address_i = a;
    req_wdata_i   = d;
    req_valid_i   = 1'b1;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      check("handshake_timeout", 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    if (expect_rsp) begin
      if (w) begin
        ref_mem[a] = d;
        exp_q.push_back(8'h00);
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || id_q.size() != 0 || !req_ready_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_rsp_queue", exp_q.size(), 0);
    check("drain_id_queue", id_q.size(), 0);
  endtask

  initial begin
    logic [7:0] id_src;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_address_i = 3'd0;
    req_wdata_i = 8'h00;
    ireq_n_i = 1'b1;
    repeat (3) @(negedge clk_i);

    check("rst_cs_n", chip_sel_n_o, 1);
    check("rst_rw", read_write_o, 1);
    check("rst_oe", data_oe_o, 0);
    check("rst_addr", address_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_id_valid", irq_id_valid_o, 0);
    check("rst_id", irq_id_o, 0);
    rst_n = 1'b1;
    @(negedge clk_i);
    check("rst_ready", req_ready_o, 1);
    proto_en = 1;

    // Write 0xA5 to address 3; send returns in cycle 1
    send(1'b1, 3'd3, 8'hA5, 1);
    req_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk_i);
      check("wr_oe", data_oe_o, (k <= 3));
      check("wr_cs_n", chip_sel_n_o, !(k == 2 || k == 3));
      check("wr_ready", req_ready_o, (k == 5));
      check("wr_rsp_valid", rsp_valid_o, (k == 4));
      if (k == 2) begin
        check("wr_addr", address_o, 3);
        check("wr_data", data_o, 8'hA5);
        check("wr_rw", read_write_o, 0);
      end
    end

    // Read address 5 after loading it with 0x3C
    send(1'b1, 3'd5, 8'h3C, 1);
    req_valid_i = 1'b0;
    drain();
    send(1'b0, 3'd5, 8'($urandom), 1);
    req_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk_i);
      check("rd_oe", data_oe_o, 0);
      if (k == 2) check("rd_rw", read_write_o, 1);
      if (k == 4) begin
        check("rd_rsp_valid", rsp_valid_o, 1);
        check("rd_rdata", rsp_rdata_o, 8'h3C);
      end
    end
    drain();

    // Reset asserted in cycle 2 of a write
    proto_en = 0;
    send(1'b1, 3'd2, 8'h11, 0);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b0;
    @(negedge clk_i);
    check("abort_cs_n", chip_sel_n_o, 1);
    check("abort_ready", req_ready_o, 1);
    check("abort_rsp_valid", rsp_valid_o, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    repeat (6) @(negedge clk_i);
    check("abort_no_rsp", rsp_cyc < cyc - 6, 1);
    proto_en = 1;

    // Fill every register back-to-back, then random mixed traffic
    for (int i = 0; i < 8; i++) send(1'b1, 3'(i), 8'($urandom), 1);
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        req_valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
    end
    req_valid_i = 1'b0;
    drain();

    // Interrupt: load an ID source at register 0, then assert ireq_n_i
    id_src = 8'h04;
    send(1'b1, 3'd0, id_src, 1);
    req_valid_i = 1'b0;
    drain();
    ireq_n_i = 1'b0;
    @(negedge clk_i);
    check("irq_lat_1", irq_o, 0);
    @(negedge clk_i);
    check("irq_lat_2", irq_o, 1);
`ifdef UART_BUS_MASTER_AUTO_IRQ_EN
    id_q.push_back(ref_mem[0][2:0]);
    @(negedge clk_i);
    check("irq_fetch_blocks_ready", req_ready_o, 0);
`else
    @(negedge clk_i);
`endif
    send(1'b0, 3'($urandom_range(1, 7)), 8'h00, 1);
    req_valid_i = 1'b0;
    drain();
`ifdef UART_BUS_MASTER_AUTO_IRQ_EN
    check("irq_id_before_host_rsp", (id_cyc != 0) && (id_cyc < rsp_cyc), 1);
`else
    check("irq_id_tied", {irq_id_valid_o, irq_id_o}, 0);
`endif
    ireq_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("irq_release", irq_o, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
